jacobi_sram_seq: RTL and testbench

- Control sequencer for one Jacobi sweep engine.
- Walks a ping-pong SRAM pair element by element, for a programmable number of elements and iterations.
- For each element it reads the source bank, then arms the downstream operation counter via countEN and waits for its op_done pulse. It then writes the destination bank.
- Drives the operation counter directly and reports busy/done/error to the top-level controller.

---
 rtl/jacobi_sram_seq.sv | 162 ++++++++++++++++
 tb/tb_jacobi_sram_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_sram_seq.sv
// Control sequencer for one Jacobi sweep engine: walks a ping-pong SRAM pair,
// handshaking each element with the downstream operation counter.
module jacobi_sram_seq #(
  parameter int ADDR_W   = 6,
  parameter int ITER_W   = 4,
  parameter int WAIT_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_elem,
  input  logic [ITER_W-1:0] num_iter,
  input  logic              op_done,
  output logic              countEN,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, NEXT, FIN} state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] idx_r, idx_nxt_s;
  logic [ADDR_W-1:0] num_elem_r, num_elem_nxt_s;
  logic [ITER_W-1:0] num_iter_r, num_iter_nxt_s;
  logic [ITER_W-1:0] iter_r, iter_nxt_s;
  logic [WAIT_W-1:0] wait_r, wait_nxt_s;
  logic              bank_r, bank_nxt_s;
  logic              error_r, error_nxt_s;
  logic              count_en_r, rd_en_r, wr_en_r, busy_r, done_r;
  logic [ADDR_W:0]   rd_addr_r, wr_addr_r;

  // Next-state and next-counter logic for the sweep walk
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    num_elem_nxt_s = num_elem_r;
    num_iter_nxt_s = num_iter_r;
    iter_nxt_s     = iter_r;
    wait_nxt_s     = wait_r;
    bank_nxt_s     = bank_r;
    error_nxt_s    = error_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          num_elem_nxt_s = num_elem;
          num_iter_nxt_s = num_iter;
          error_nxt_s    = 1'b0;
          idx_nxt_s      = '0;
          iter_nxt_s     = '0;
          bank_nxt_s     = 1'b0;
          if ((num_elem == '0) || (num_iter == '0)) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = READ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        wait_nxt_s  = '0;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (op_done) begin
          state_nxt_s = WRITE;
        end else if (wait_r == WAIT_LAST) begin
          // Counter never answered: abandon the run without writing
          error_nxt_s = 1'b1;
          state_nxt_s = FIN;
        end else begin
          wait_nxt_s = wait_r + WAIT_W'(1);
        end
      end
      WRITE: begin
        if (idx_r == (num_elem_r - ADDR_W'(1))) begin
          state_nxt_s = NEXT;
        end else begin
          idx_nxt_s   = idx_r + ADDR_W'(1);
          state_nxt_s = READ;
        end
      end
      NEXT: begin
        iter_nxt_s = iter_r + ITER_W'(1);
        bank_nxt_s = ~bank_r;
        idx_nxt_s  = '0;
        if ((iter_r + ITER_W'(1)) == num_iter_r) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      num_elem_r <= '0;
      num_iter_r <= '0;
      iter_r     <= '0;
      wait_r     <= '0;
      bank_r     <= 1'b0;
      error_r    <= 1'b0;
      count_en_r <= 1'b0;
      rd_en_r    <= 1'b0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_addr_r  <= '0;
      wr_addr_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      num_elem_r <= num_elem_nxt_s;
      num_iter_r <= num_iter_nxt_s;
      iter_r     <= iter_nxt_s;
      wait_r     <= wait_nxt_s;
      bank_r     <= bank_nxt_s;
      error_r    <= error_nxt_s;
      count_en_r <= (state_nxt_s == WAIT);
      rd_en_r    <= (state_nxt_s == READ);
      wr_en_r    <= (state_nxt_s == WRITE);
      busy_r     <= (state_nxt_s != IDLE);
      done_r     <= (state_nxt_s == FIN);
      if (state_nxt_s == READ) begin
        rd_addr_r <= {bank_nxt_s, idx_nxt_s};
      end
      if (state_nxt_s == WRITE) begin
        wr_addr_r <= {~bank_nxt_s, idx_nxt_s};
      end
    end
  end

  assign countEN  = count_en_r;
  assign rd_en    = rd_en_r;
  assign rd_addr  = rd_addr_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign iter_cnt = iter_r;

endmodule

// File: tb/tb_jacobi_sram_seq.sv
// Self-checking bench for jacobi_sram_seq: table of runs with an address
// scoreboard, plus hand-written busy-start, spurious op_done and abort sequences.
module tb_jacobi_sram_seq;

  localparam int ADDR_W   = 6;
  localparam int ITER_W   = 4;
  localparam int WAIT_MAX = 8;
  localparam int NORM     = 0;
  localparam int NEVER    = 1;

  typedef struct {
    int ne;
    int ni;
    int mode;
    int cyc_min;
    int cyc_max;
    int err;
    int iters;
    int writes;
    int cens;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_elem = '0;
  logic [ITER_W-1:0] num_iter = '0;
  logic              op_done;
  logic              countEN, rd_en, wr_en, busy, done, error;
  logic [ADDR_W:0]   rd_addr, wr_addr;
  logic [ITER_W-1:0] iter_cnt;

  logic resp_r = 1'b0;
  logic spur_s = 1'b0;
  int   mode = NORM;
  int   total = 0;
  int   bad = 0;
  int   rd_seen = 0, wr_seen = 0, cen_seen = 0, done_seen = 0;
  logic [ADDR_W:0] rd_q[$];
  logic [ADDR_W:0] wr_q[$];
  vec_t vecs[7];

  assign op_done = resp_r | spur_s;

  jacobi_sram_seq #(.ADDR_W(ADDR_W), .ITER_W(ITER_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clock(clock), .reset(reset), .start(start), .num_elem(num_elem),
    .num_iter(num_iter), .op_done(op_done), .countEN(countEN), .rd_en(rd_en),
    .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy),
    .done(done), .error(error), .iter_cnt(iter_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Operation counter model: op_done one cycle after countEN rises
  always @(posedge clock or negedge reset) begin
    if (!reset) resp_r <= 1'b0;
    else if (mode == NORM) resp_r <= countEN & ~resp_r;
    else resp_r <= 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: pops expected addresses as strobes appear
  always @(negedge clock) begin
    if (reset) begin
      if (rd_en) begin
        rd_seen++;
        if (rd_q.size() == 0) chk("rd_unexpected", {25'd0, rd_addr}, 32'hFFFF_FFFF);
        else chk("rd_addr", {25'd0, rd_addr}, {25'd0, rd_q.pop_front()});
      end
      if (wr_en) begin
        wr_seen++;
        if (wr_q.size() == 0) chk("wr_unexpected", {25'd0, wr_addr}, 32'hFFFF_FFFF);
        else chk("wr_addr", {25'd0, wr_addr}, {25'd0, wr_q.pop_front()});
      end
      if (rd_en && wr_en) chk("rd_wr_excl", 32'd1, 32'd0);
      if (countEN) cen_seen++;
      if (done) done_seen++;
    end
  end

  task automatic push_expect(input vec_t v);
    if (v.ne > 0 && v.ni > 0) begin
      if (v.mode == NEVER) begin
        rd_q.push_back(7'd0);
      end else begin
        for (int i = 0; i < v.ni; i++) begin
          for (int e = 0; e < v.ne; e++) begin
            rd_q.push_back(7'((i % 2) * 64 + e));
            wr_q.push_back(7'(((i + 1) % 2) * 64 + e));
          end
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    mode = v.mode;
    num_elem = ADDR_W'(v.ne);
    num_iter = ITER_W'(v.ni);
    rd_seen = 0; wr_seen = 0; cen_seen = 0; done_seen = 0;
    push_expect(v);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_err_clear"}, {31'd0, error}, {31'd0, (v.mode == NEVER && v.cyc_min == 1) ? 1'b1 : 1'b0});
    while (!done && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    chk_rng({tag, "_done_cycle"}, cyc, v.cyc_min, v.cyc_max);
    chk({tag, "_error"}, {31'd0, error}, 32'(v.err));
    chk({tag, "_iter_cnt"}, {28'd0, iter_cnt}, 32'(v.iters));
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk({tag, "_busy_after"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_writes"}, 32'(wr_seen), 32'(v.writes));
    chk({tag, "_countEN_cycles"}, 32'(cen_seen), 32'(v.cens));
    chk({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
    chk({tag, "_queues_left"}, 32'(rd_q.size() + wr_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
    mode = NORM;
  endtask

  task automatic inject_busy_noise();
    int n;
    n = 0;
    while (!rd_en && n < 50) begin @(negedge clock); n++; end
    spur_s = 1'b1; start = 1'b1; num_elem = 6'd5; num_iter = 4'd3;
    @(negedge clock);
    spur_s = 1'b0; start = 1'b0;
    n = 0;
    while (!wr_en && n < 50) begin @(negedge clock); n++; end
    spur_s = 1'b1;
    @(negedge clock);
    spur_s = 1'b0;
  endtask

  initial begin
    vec_t sp;
    vec_t rr;
    int n;
    vecs[0] = '{3, 2, NORM, 27, 27, 0, 2, 6, 12};
    vecs[1] = '{0, 5, NORM, 1, 2, 0, 0, 0, 0};
    vecs[2] = '{4, 0, NORM, 1, 2, 0, 0, 0, 0};
    vecs[3] = '{3, 2, NEVER, 10, 10, 1, 0, 0, 8};
    vecs[4] = '{2, 3, NORM, 28, 28, 0, 3, 6, 12};
    vecs[5] = '{63, 1, NORM, 254, 254, 0, 1, 63, 126};
    vecs[6] = '{1, 1, NORM, 6, 6, 0, 1, 1, 2};

    // reset held with start asserted
    start = 1'b1; num_elem = 6'd3; num_iter = 4'd2;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {8'd0, countEN, rd_en, rd_addr, wr_en, wr_addr, busy, done, error, iter_cnt}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    rd_seen = 0; wr_seen = 0;
    repeat (10) @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_strobes", 32'(rd_seen + wr_seen), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // start while busy and spurious op_done must not disturb the run
    sp = '{2, 2, NORM, 19, 19, 0, 2, 4, 8};
    fork
      run_vec(sp, "busy_noise");
      inject_busy_noise();
    join
    num_elem = '0; num_iter = '0;

    // abort in the second WAIT cycle of the second iteration
    rr = '{3, 2, NORM, 27, 27, 0, 2, 6, 12};
    push_expect(rr);
    num_elem = 6'd3; num_iter = 4'd2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(iter_cnt == 4'd1 && countEN) && n < 100) begin @(negedge clock); n++; end
    chk("abort_reached", 32'(n < 100), 32'd1);
    @(negedge clock);
    chk("abort_second_wait", {31'd0, countEN}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", {8'd0, countEN, rd_en, rd_addr, wr_en, wr_addr, busy, done, error, iter_cnt}, 32'd0);
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    rd_seen = 0; wr_seen = 0;
    repeat (3) @(negedge clock);
    chk("abort_quiet", 32'(rd_seen + wr_seen), 32'd0);
    run_vec('{2, 1, NORM, 10, 10, 0, 1, 2, 4}, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
